// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multi-cycle MIPS controller.
//   - state encodings (IDLE..JUMP), opcode constants
//   - mux-select / ALU-op code constants
//   - ctrl_t: the full control word driven to the datapath
//   - isLegal(): opcode legality check used by the DECODE dispatch
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    EXEC_I   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  // alu_src_b
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  // alu_op
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;
  localparam logic [1:0] ALU_LOGIC   = 2'b11;
  // pc_source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       extZero;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic isLegal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI: isLegal = 1'b1;
      default:                  isLegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational control-word decoder.
//   state     - current FSM state
//   opcode    - live IR[31:26], only consulted in DECODE (illegal flag)
//   opLat     - opcode latched in DECODE, selects extender/ALU mode for I-type
//   memReady  - qualifies ir_write/pc_write in FETCH
//   ctrl      - full control word
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] opLat,
  input  logic            memReady,
  output ctrl_t           ctrl
);

  logic logicImm;
  assign logicImm = (opLat == OP_ANDI) || (opLat == OP_ORI);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALU_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.irWrite  = memReady;
        ctrl.pcWrite  = memReady;
      end
      DECODE: begin
        // branch target precompute: PC + (sext(imm) << 2)
        ctrl.aluSrcB   = SRCB_IMM_SH;
        ctrl.aluOp     = ALU_ADD;
        ctrl.illegalOp = !isLegal(opcode);
      end
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      MEM_WR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = logicImm ? ALU_LOGIC : ALU_ADD;
        ctrl.extZero = logicImm;
      end
      I_WB: begin
        ctrl.regWrite = 1'b1;
        // extender mode held so the immediate path stays stable through writeback
        ctrl.extZero  = logicImm;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_B;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      default: ctrl = '0; // IDLE and unreachable encodings
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multi-cycle MIPS datapath.
//   clk, rst (async, active high)
//   opcode     - IR[31:26], valid from DECODE on; latched in DECODE
//   mem_ready  - memory completes current access this cycle
//   outputs    - PC/IR/regfile/memory enables, mux selects, ALU op,
//                extender mode, one-cycle illegal_op pulse in DECODE
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = mips_ctrl_pkg::OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            ext_zero,
  output logic            illegal_op
);

  state_t          state, stateNxt;
  logic [OP_W-1:0] opLat;
  ctrl_t           ctrl;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // opcode held from DECODE so later states are independent of IR
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  opLat <= '0;
    else if (state == DECODE) opLat <= opcode;
  end

  // next state
  always_comb begin
    stateNxt = FETCH;
    case (state)
      IDLE:     stateNxt = FETCH;
      FETCH:    stateNxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              stateNxt = MEM_ADDR;
          OP_RTYPE:                  stateNxt = EXEC_R;
          OP_BEQ:                    stateNxt = BRANCH;
          OP_J:                      stateNxt = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  stateNxt = EXEC_I;
          default:                   stateNxt = FETCH;
        endcase
      end
      MEM_ADDR: stateNxt = (opLat == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   stateNxt = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   stateNxt = FETCH;
      MEM_WR:   stateNxt = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   stateNxt = R_WB;
      R_WB:     stateNxt = FETCH;
      EXEC_I:   stateNxt = I_WB;
      I_WB:     stateNxt = FETCH;
      BRANCH:   stateNxt = FETCH;
      JUMP:     stateNxt = FETCH;
      default:  stateNxt = FETCH;
    endcase
  end

  // outputs
  mips_ctrl_outdec uOutdec (
    .state    (state),
    .opcode   (opcode),
    .opLat    (opLat),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  always_comb begin
    pc_write      = ctrl.pcWrite;
    pc_write_cond = ctrl.pcWriteCond;
    iord          = ctrl.iord;
    mem_read      = ctrl.memRead;
    mem_write     = ctrl.memWrite;
    ir_write      = ctrl.irWrite;
    mem_to_reg    = ctrl.memToReg;
    reg_dst       = ctrl.regDst;
    reg_write     = ctrl.regWrite;
    alu_src_a     = ctrl.aluSrcA;
    alu_src_b     = ctrl.aluSrcB;
    alu_op        = ctrl.aluOp;
    pc_source     = ctrl.pcSource;
    ext_zero      = ctrl.extZero;
    illegal_op    = ctrl.illegalOp;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: the driver expands each instruction into its expected
// per-cycle control words (from the instruction's class and wait states) and
// pushes them; the monitor pops one per cycle and compares at the falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, iord, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       extZero, illegalOp;
  } cw_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
    cw_t        cw;
  } step_t;

  logic       clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .ext_zero(ext_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  cw_t   sbQ[$];
  step_t plan[$];
  int    nCmp = 0, nErr = 0, cyc = 0;

  // monitor
  always @(negedge clk) begin
    cw_t act, exp;
    cyc++;
    act = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, ext_zero, illegal_op};
    if (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      nCmp++;
      if (act !== exp) begin
        nErr++;
        $display("FAIL ctrlword cyc=%0d actual=%b required=%b", cyc, act, exp);
      end
      if (mem_read && mem_write) begin
        nErr++;
        $display("FAIL rd_wr_overlap cyc=%0d actual=11 required=not both", cyc);
      end
    end
  end

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b001000, 6'b001100, 6'b001101};
  endfunction

  function automatic logic [5:0] rndOp();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic addStep(input logic rdy, input logic [5:0] op, input cw_t cw);
    step_t s;
    s.rdy = rdy; s.op = op; s.cw = cw;
    plan.push_back(s);
  endtask

  // Expected cycle list for one instruction. abortMem: the data access never
  // completes (the caller then pulses reset).
  task automatic planInstr(input logic [5:0] op, input int wFetch,
                           input int wMem, input bit abortMem);
    cw_t c;
    for (int i = 0; i < wFetch; i++) begin
      c = '0; c.memRead = 1; c.aluSrcB = 2'b01;
      addStep(1'b0, rndOp(), c);
    end
    c = '0; c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = 1; c.pcWrite = 1;
    addStep(1'b1, rndOp(), c);
    c = '0; c.aluSrcB = 2'b11; c.illegalOp = !legal(op);
    addStep(1'($urandom_range(0, 1)), op, c);
    // after DECODE the IR field is scrambled: control must use the latched op
    case (op)
      6'b100011, 6'b101011: begin
        c = '0; c.aluSrcA = 1; c.aluSrcB = 2'b10;
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
        c = '0; c.iord = 1;
        if (op == 6'b100011) c.memRead = 1; else c.memWrite = 1;
        for (int i = 0; i < wMem; i++) addStep(1'b0, rndOp(), c);
        if (!abortMem) begin
          addStep(1'b1, rndOp(), c);
          if (op == 6'b100011) begin
            c = '0; c.regWrite = 1; c.memToReg = 1;
            addStep(1'($urandom_range(0, 1)), rndOp(), c);
          end
        end
      end
      6'b000000: begin
        c = '0; c.aluSrcA = 1; c.aluOp = 2'b10;
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
        c = '0; c.regWrite = 1; c.regDst = 1;
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
      end
      6'b001000, 6'b001100, 6'b001101: begin
        c = '0; c.aluSrcA = 1; c.aluSrcB = 2'b10;
        c.extZero = (op != 6'b001000);
        c.aluOp   = (op == 6'b001000) ? 2'b00 : 2'b11;
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
        c = '0; c.regWrite = 1; c.extZero = (op != 6'b001000);
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
      end
      6'b000100: begin
        c = '0; c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01;
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
      end
      6'b000010: begin
        c = '0; c.pcWrite = 1; c.pcSource = 2'b10;
        addStep(1'($urandom_range(0, 1)), rndOp(), c);
      end
      default: ; // illegal: straight back to FETCH
    endcase
  endtask

  task automatic runPlan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk); #1;
      mem_ready = s.rdy; opcode = s.op;
      sbQ.push_back(s.cw);
    end
  endtask

  // Reset asserted mid-cycle (asynchronously), held one edge, then an IDLE cycle.
  task automatic resetPulse();
    @(posedge clk); #1;
    mem_ready = 1'b0; rst = 1'b1;
    sbQ.push_back('0);
    @(posedge clk); #1;
    rst = 1'b0;
    sbQ.push_back('0);
  endtask

  logic [5:0] legalOps [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000010, 6'b001000, 6'b001100, 6'b001101};

  initial begin
    logic [5:0] op;
    // reset state while rst is held, then the IDLE cycle
    repeat (2) begin @(posedge clk); #1; sbQ.push_back('0); end
    @(posedge clk); #1; rst = 1'b0; sbQ.push_back('0);

    planInstr(6'b000000, 0, 0, 0);   // R-type, 4 cycles
    planInstr(6'b100011, 0, 2, 0);   // lw, 2 wait states -> 7 cycles
    planInstr(6'b001101, 0, 0, 0);   // ori
    planInstr(6'b001000, 0, 0, 0);   // addi
    planInstr(6'b001100, 1, 0, 0);   // andi, fetch wait
    planInstr(6'b000100, 0, 0, 0);   // beq
    planInstr(6'b000010, 0, 0, 0);   // j
    planInstr(6'b111111, 0, 0, 0);   // illegal
    planInstr(6'b101011, 0, 1, 0);   // sw, 1 wait
    planInstr(6'b101011, 0, 2, 1);   // sw stuck in MEM_WR
    runPlan();
    resetPulse();

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) == 0) op = rndOp();
      else                           op = legalOps[$urandom_range(0, 7)];
      planInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      runPlan();
    end

    planInstr(6'b101011, 1, 3, 1);
    runPlan();
    resetPulse();
    planInstr(6'b000000, 0, 0, 0);
    runPlan();

    @(negedge clk); #1;
    if (sbQ.size() != 0) begin
      nErr++;
      $display("FAIL drain actual=%0d left required=0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath: PC, IR, register file, ALU, memory, and the sign-extend unit.
- Per state, it drives every mux select and write enable.
- It configures the extender for sign or zero extension.
- It stalls on a memory ready handshake and flags illegal opcodes.
- It sits beside the datapath top level and takes only the opcode field and the memory ready signal as status inputs.

Parameters:
- OP_W, 6, opcode field width.
- STATE_W, 4, state register width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from the DECODE state on.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback data select: 1 = MDR.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = logic immediate (andi/ori).
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset:
  - rst=1 forces the state to IDLE asynchronously.
  - All outputs are 0 in IDLE.
  - IDLE always moves to FETCH on the next edge.
  - Reset mid-instruction abandons it; no write enable survives the reset.
- Outputs are decoded from the state only, except the qualified enables below.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Holds while mem_ready=0; moves to DECODE when mem_ready=1.
  - Minimum fetch is 1 cycle.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00, ext_zero=0 (branch target precompute).
  - Dispatch by opcode:
    - 100011 (lw) and 101011 (sw) -> MEM_ADDR.
    - 000000 (R-type) -> EXEC_R.
    - 000100 (beq) -> BRANCH.
    - 000010 (j) -> JUMP.
    - 001000 (addi), 001100 (andi), 001101 (ori) -> EXEC_I.
    - Any other opcode -> FETCH, with illegal_op=1 in the DECODE cycle.
- MEM_ADDR:
  - Drives alu_src_a=1, alu_src_b=10, alu_op=00, ext_zero=0.
  - lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD:
  - Drives mem_read=1, iord=1.
  - Waits on mem_ready, then -> MEM_WB.
- MEM_WB:
  - Drives reg_write=1, mem_to_reg=1, reg_dst=0.
  - -> FETCH.
- MEM_WR:
  - Drives mem_write=1, iord=1.
  - Waits on mem_ready, then -> FETCH.
- EXEC_R:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=10.
  - -> R_WB.
- R_WB:
  - Drives reg_write=1, reg_dst=1, mem_to_reg=0.
  - -> FETCH.
- EXEC_I:
  - Drives alu_src_a=1, alu_src_b=10.
  - addi: alu_op=00, ext_zero=0. andi/ori: alu_op=11, ext_zero=1.
  - -> I_WB.
- I_WB:
  - Drives reg_write=1, reg_dst=0, mem_to_reg=0.
  - Holds ext_zero at its EXEC_I value.
  - -> FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, ext_zero=0.
  - -> FETCH.
- JUMP:
  - Drives pc_write=1, pc_source=10.
  - -> FETCH.
- Opcode latching:
  - The opcode is sampled only in DECODE.
  - It is latched into an internal op register so EXEC_I, I_WB and MEM_ADDR do not depend on IR after DECODE.
- Memory handshake:
  - mem_read and mem_write are never asserted together.
  - Requests stay high continuously until the cycle in which mem_ready=1.
  - mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Latency with zero wait states:
  - R-type, addi, andi, ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j: 3 cycles.
  - Each memory wait cycle adds 1.
- Unreachable state encodings -> FETCH, with all outputs 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12.
  - Opcode constants.
  - alu_src_b, alu_op and pc_source code constants.
- One natural sub-module: mips_ctrl_outdec, the combinational state+op to control-word decoder.
- The next-state register and handshake stay in the top.

Test Plan:
- Reset then opcode=000000, mem_ready=1:
  - IDLE -> FETCH (ir_write=1, pc_write=1) -> DECODE -> EXEC_R (alu_op=10) -> R_WB (reg_write=1, reg_dst=1) -> FETCH.
  - 4 cycles after IDLE.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD:
  - mem_read=1, iord=1 held for 3 cycles; MEM_WB has mem_to_reg=1, reg_write=1.
  - Total 7 cycles.
- ori (001101):
  - EXEC_I shows ext_zero=1, alu_op=11, alu_src_b=10.
  - addi (001000) shows ext_zero=0, alu_op=00.
- beq (000100):
  - BRANCH has pc_write_cond=1, alu_op=01, pc_source=01.
  - j (000010): JUMP has pc_write=1, pc_source=10.
  - Each returns to FETCH after 3 cycles.
- Opcode 111111:
  - illegal_op=1 for exactly the DECODE cycle; next state FETCH.
  - No reg_write or mem_write pulse.
- rst pulsed mid-way through MEM_WR while mem_ready=0:
  - Outputs drop to 0 immediately (asynchronous), mem_write=0.
  - The FSM restarts IDLE -> FETCH after rst deasserts.
